// File: rtl/intersection_phase_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : intersection_phase_ctrl                                         |
// | Brief    : EW/NS phase sequencer with latched pedestrian walk service.     |
// |            Optional macro EMERGENCY_PREEMPT_EN adds the i_preempt override. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module intersection_phase_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 2,
    parameter int T_LEFT   = 10,
    parameter int T_FLASH  = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [1:0] i_ped_req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic [1:0] i_preempt,
`endif
    output logic [3:0] o_ew_ct,
    output logic [3:0] o_ns_ct,
    output logic [1:0] o_ew_wt,
    output logic [1:0] o_ns_wt,
    output logic [3:0] o_phase,
    output logic       o_tick
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_TMAX  = (T_GREEN > T_LEFT)
                             ? ((T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW)
                             : ((T_LEFT  > T_YELLOW) ? T_LEFT  : T_YELLOW);
    localparam int c_TMR_W = $clog2(c_TMAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_TMR_W-1:0] c_G_LAST   = c_TMR_W'(T_GREEN - 1);
    localparam logic [c_TMR_W-1:0] c_Y_LAST   = c_TMR_W'(T_YELLOW - 1);
    localparam logic [c_TMR_W-1:0] c_L_LAST   = c_TMR_W'(T_LEFT - 1);
    localparam logic [c_TMR_W-1:0] c_WALK_LEN = c_TMR_W'(T_GREEN - T_FLASH);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_EW_G  = 4'd1;
    localparam logic [3:0] c_EW_Y1 = 4'd2;
    localparam logic [3:0] c_EW_L  = 4'd3;
    localparam logic [3:0] c_EW_Y2 = 4'd4;
    localparam logic [3:0] c_NS_G  = 4'd5;
    localparam logic [3:0] c_NS_Y1 = 4'd6;
    localparam logic [3:0] c_NS_L  = 4'd7;
    localparam logic [3:0] c_NS_Y2 = 4'd8;

    localparam logic [3:0] c_LAMP_OFF = 4'b0000;
    localparam logic [3:0] c_LAMP_G   = 4'b0001;
    localparam logic [3:0] c_LAMP_L   = 4'b0010;
    localparam logic [3:0] c_LAMP_Y   = 4'b0100;
    localparam logic [3:0] c_LAMP_R   = 4'b1000;
    localparam logic [1:0] c_WALK_OFF  = 2'b00;
    localparam logic [1:0] c_WALK_GO   = 2'b01;
    localparam logic [1:0] c_WALK_STOP = 2'b10;

    logic [3:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMR_W-1:0] r_tmr;
    logic [1:0]         r_req;
    logic               r_ew_grant;
    logic               r_ns_grant;

    logic               w_tick, w_last, w_adv, w_clr_cnt;
    logic               w_pre_act, w_hold, w_is_yel, w_flash_on;
    logic [3:0]         w_next, w_seq_next, w_yel_next, w_pre_tgt;
    logic [c_TMR_W-1:0] w_dur_last;
    logic [1:0]         w_req_set, w_req_nxt, w_ew_walk, w_ns_walk;

`ifdef EMERGENCY_PREEMPT_EN
    assign w_pre_act = |i_preempt;
    assign w_pre_tgt = i_preempt[1] ? c_NS_G : c_EW_G;
`else
    assign w_pre_act = 1'b0;
    assign w_pre_tgt = c_EW_G;
`endif
    assign w_hold = w_pre_act && (r_state == w_pre_tgt);
    assign w_tick = (r_state != c_IDLE) && (r_cnt == c_CNT_LAST);
    assign w_last = w_tick && (r_tmr == w_dur_last);

    always_comb begin
        w_dur_last = c_G_LAST;
        w_seq_next = c_IDLE;
        w_yel_next = r_state;
        w_is_yel   = 1'b0;
        case (r_state)
            c_EW_G : begin w_seq_next = c_EW_Y1; w_yel_next = c_EW_Y1; end
            c_EW_Y1: begin w_dur_last = c_Y_LAST; w_seq_next = c_EW_L;  w_is_yel = 1'b1; end
            c_EW_L : begin w_dur_last = c_L_LAST; w_seq_next = c_EW_Y2; w_yel_next = c_EW_Y2; end
            c_EW_Y2: begin w_dur_last = c_Y_LAST; w_seq_next = c_NS_G;  w_is_yel = 1'b1; end
            c_NS_G : begin w_seq_next = c_NS_Y1; w_yel_next = c_NS_Y1; end
            c_NS_Y1: begin w_dur_last = c_Y_LAST; w_seq_next = c_NS_L;  w_is_yel = 1'b1; end
            c_NS_L : begin w_dur_last = c_L_LAST; w_seq_next = c_NS_Y2; w_yel_next = c_NS_Y2; end
            c_NS_Y2: begin w_dur_last = c_Y_LAST; w_seq_next = c_EW_G;  w_is_yel = 1'b1; end
            default: w_seq_next = c_IDLE;
        endcase
    end

    // Preempt jumps restart the tick counter so the forced yellow runs its full length
    always_comb begin
        w_next    = r_state;
        w_adv     = 1'b0;
        w_clr_cnt = 1'b0;
        if (r_state == c_IDLE) begin
            w_clr_cnt = 1'b1;
            if (i_start) begin
                w_next = c_EW_G;
                w_adv  = 1'b1;
            end
        end else if (w_hold) begin
            w_clr_cnt = 1'b1;
        end else if (w_pre_act && !w_is_yel) begin
            w_next    = w_yel_next;
            w_adv     = 1'b1;
            w_clr_cnt = 1'b1;
        end else if (w_last) begin
            w_next = (w_is_yel && w_pre_act) ? w_pre_tgt : w_seq_next;
            w_adv  = 1'b1;
        end
    end

    // A press on the consuming edge wins over the clear
    always_comb begin
        w_req_set = (r_state != c_IDLE) ? i_ped_req : 2'b00;
        w_req_nxt = r_req | w_req_set;
        if (w_adv && !w_pre_act && (w_next == c_EW_G)) w_req_nxt[1] = w_req_set[1];
        if (w_adv && !w_pre_act && (w_next == c_NS_G)) w_req_nxt[0] = w_req_set[0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_req      <= 2'b00;
            r_ew_grant <= 1'b0;
            r_ns_grant <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= w_req_nxt;
            if (w_clr_cnt || (r_cnt == c_CNT_LAST)) r_cnt <= '0;
            else                                    r_cnt <= r_cnt + 1'b1;
            if (w_adv || w_hold || (r_state == c_IDLE)) r_tmr <= '0;
            else if (w_tick)                            r_tmr <= r_tmr + 1'b1;
            if (w_adv && (w_next == c_EW_G)) r_ns_grant <= r_req[1] && !w_pre_act;
            if (w_adv && (w_next == c_NS_G)) r_ew_grant <= r_req[0] && !w_pre_act;
        end
    end

    // Flash index parity: even index dark, odd index lit
    assign w_flash_on = (r_tmr < c_WALK_LEN) || (r_tmr[0] ^ c_WALK_LEN[0]);
    assign w_ew_walk  = (r_ew_grant && !w_hold) ? (w_flash_on ? c_WALK_GO : c_WALK_OFF) : c_WALK_STOP;
    assign w_ns_walk  = (r_ns_grant && !w_hold) ? (w_flash_on ? c_WALK_GO : c_WALK_OFF) : c_WALK_STOP;

    always_comb begin
        o_ew_ct = c_LAMP_R;
        o_ns_ct = c_LAMP_R;
        o_ew_wt = c_WALK_STOP;
        o_ns_wt = c_WALK_STOP;
        case (r_state)
            c_EW_G : begin o_ew_ct = c_LAMP_G; o_ns_wt = w_ns_walk; end
            c_EW_Y1,
            c_EW_Y2: o_ew_ct = c_LAMP_Y;
            c_EW_L : o_ew_ct = c_LAMP_L;
            c_NS_G : begin o_ns_ct = c_LAMP_G; o_ew_wt = w_ew_walk; end
            c_NS_Y1,
            c_NS_Y2: o_ns_ct = c_LAMP_Y;
            c_NS_L : o_ns_ct = c_LAMP_L;
            default: begin
                o_ew_ct = c_LAMP_OFF;
                o_ns_ct = c_LAMP_OFF;
                o_ew_wt = c_WALK_OFF;
                o_ns_wt = c_WALK_OFF;
            end
        endcase
    end

    assign o_phase = r_state;
    assign o_tick  = w_tick;

endmodule

`default_nettype wire
